sm_1118_spm_scheduler: RTL and testbench

- Sequencer between the Xbee SPM receiver and the bot's motion/pickup controller.
- Captures the streamed (rx_index, rx_color) supply-position entries into a slot table.
- Issues non-empty slots one at a time as tasks over a valid/ready handshake, then waits for a completion pulse.
- Flags all_done when every non-empty slot has been served.

---
 rtl/sm_1118_pkg.sv | 26 ++
 rtl/sm_1118_slot_picker.sv | 48 ++++
 rtl/sm_1118_spm_scheduler.sv | 138 +++++++++++++
 tb/tb_sm_1118_spm_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_1118_pkg.sv
// Shared definitions for the SPM scheduler: color codes, FSM state
// encoding and default sizing.
package sm_1118_pkg;

  // Default number of supply-position slots (indexed 1..NUM_SLOTS).
  localparam int NUM_SLOTS_DEF = 7;
  // Default width of slot index buses; 2**IDX_W must exceed NUM_SLOTS.
  localparam int IDX_W_DEF     = 4;

  // Color codes as streamed by the receiver. The numeric order R < B < G
  // is also the service order when color priority is enabled.
  localparam logic [1:0] COLOR_NONE = 2'd0;
  localparam logic [1:0] COLOR_R    = 2'd1;
  localparam logic [1:0] COLOR_B    = 2'd2;
  localparam logic [1:0] COLOR_G    = 2'd3;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    COLLECT   = 3'd0,
    SELECT    = 3'd1,
    OFFER     = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

endpackage : sm_1118_pkg

// File: rtl/sm_1118_slot_picker.sv
// Combinational next-slot finder: returns the first slot that holds a
// color and has not yet been served.
// Build option SM_1118_COLOR_PRIORITY_EN: when defined, all R slots are
// returned first (ascending index), then all B, then all G. When not
// defined, slots are returned in plain ascending order.
module sm_1118_slot_picker
  import sm_1118_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic [NUM_SLOTS-1:0][1:0] colors_i,  // entry i holds slot i+1
  input  logic [NUM_SLOTS-1:0]      served_i,  // bit i set once slot i+1 completed
  output logic                      found_o,
  output logic [IDX_W-1:0]          slot_o,
  output logic [1:0]                color_o
);

  // Priority search; the hit flag freezes the first match found.
  always_comb begin
    logic hit;
    hit     = 1'b0;
    slot_o  = '0;
    color_o = COLOR_NONE;
`ifdef SM_1118_COLOR_PRIORITY_EN
    // Outer pass walks the color codes R, B, G in that order.
    for (int p = 1; p <= 3; p++) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (!hit && !served_i[i] && (colors_i[i] == 2'(p))) begin
          hit     = 1'b1;
          slot_o  = IDX_W'(i + 1);
          color_o = colors_i[i];
        end
      end
    end
`else
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit && !served_i[i] && (colors_i[i] != COLOR_NONE)) begin
        hit     = 1'b1;
        slot_o  = IDX_W'(i + 1);
        color_o = colors_i[i];
      end
    end
`endif
    found_o = hit;
  end

endmodule : sm_1118_slot_picker

// File: rtl/sm_1118_spm_scheduler.sv
// SPM scheduler: captures streamed (index, color) supply-position entries
// into a slot table, then offers each non-empty slot as a task over a
// valid/ready handshake and waits for a completion pulse before moving on.
// Build option SM_1118_COLOR_PRIORITY_EN (see sm_1118_slot_picker) changes
// only the order in which slots are chosen.
//
// Handshake: task_valid is registered and, once raised, holds together
// with task_slot/task_color unchanged until a cycle in which task_ready is
// also high; that cycle is the transfer, and task_valid is low from the
// next cycle. task_done is honoured only after the transfer cycle.
module sm_1118_spm_scheduler
  import sm_1118_pkg::*;
#(
  parameter int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rx_index,
  input  logic [1:0]       rx_color,
  input  logic             restart,
  input  logic             task_ready,
  input  logic             task_done,
  output logic             task_valid,
  output logic [IDX_W-1:0] task_slot,
  output logic [1:0]       task_color,
  output logic [IDX_W-1:0] served_count,
  output logic             all_done,
  output state_t           dbg_state_o
);

  state_t                   state_q;
  logic [NUM_SLOTS-1:0][1:0] colors_q;
  logic [NUM_SLOTS-1:0]      served_q;
  logic [IDX_W-1:0]          last_idx_q;
  logic                      task_valid_q;
  logic [IDX_W-1:0]          task_slot_q;
  logic [1:0]                task_color_q;
  logic [IDX_W-1:0]          served_count_q;
  logic                      all_done_q;

  logic                      pick_found;
  logic [IDX_W-1:0]          pick_slot;
  logic [1:0]                pick_color;
  logic                      capture;
  logic                      capture_last;

  // A new table entry: index in range and different from the previous one,
  // so an index held for several cycles is written only once.
  assign capture = (rx_index != '0) &&
                   (rx_index <= IDX_W'(NUM_SLOTS)) &&
                   (rx_index != last_idx_q);
  assign capture_last = capture && (rx_index == IDX_W'(NUM_SLOTS));

  sm_1118_slot_picker #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .colors_i (colors_q),
    .served_i (served_q),
    .found_o  (pick_found),
    .slot_o   (pick_slot),
    .color_o  (pick_color)
  );

  // Scheduler FSM with table, served bits and all outputs registered.
  always_ff @(posedge clk_50m) begin
    if (!rst_n || restart) begin
      state_q        <= COLLECT;
      colors_q       <= '0;
      served_q       <= '0;
      last_idx_q     <= '0;
      task_valid_q   <= 1'b0;
      task_slot_q    <= '0;
      task_color_q   <= COLOR_NONE;
      served_count_q <= '0;
      all_done_q     <= 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (capture) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (rx_index == IDX_W'(i + 1)) colors_q[i] <= rx_color;
            end
            last_idx_q <= rx_index;
            // The last slot index closes the message; unstreamed slots
            // (early terminator) simply stay at COLOR_NONE.
            if (capture_last) state_q <= SELECT;
          end
        end
        SELECT: begin
          if (pick_found) begin
            task_slot_q  <= pick_slot;
            task_color_q <= pick_color;
            task_valid_q <= 1'b1;
            state_q      <= OFFER;
          end else begin
            all_done_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        OFFER: begin
          // task_valid_q is known high here, so task_ready alone completes
          // the transfer.
          if (task_ready) begin
            task_valid_q <= 1'b0;
            state_q      <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (task_done) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (task_slot_q == IDX_W'(i + 1)) served_q[i] <= 1'b1;
            end
            if (served_count_q < IDX_W'(NUM_SLOTS)) begin
              served_count_q <= served_count_q + IDX_W'(1);
            end
            state_q <= SELECT;
          end
        end
        DONE: begin
          all_done_q <= 1'b1;
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign task_valid   = task_valid_q;
  assign task_slot    = task_slot_q;
  assign task_color   = task_color_q;
  assign served_count = served_count_q;
  assign all_done     = all_done_q;
  assign dbg_state_o  = state_q;

endmodule : sm_1118_spm_scheduler

// File: tb/tb_sm_1118_spm_scheduler.sv
// Directed testbench for sm_1118_spm_scheduler. Expected task orders are
// hand-derived for the build selected by SM_1118_COLOR_PRIORITY_EN.
module tb_sm_1118_spm_scheduler;
  import sm_1118_pkg::*;

  localparam int IDX_W = 4;

  // ---------------- clock / reset / DUT ----------------
  logic             clk_50m = 1'b0;
  logic             rst_n;
  logic [IDX_W-1:0] rx_index;
  logic [1:0]       rx_color;
  logic             restart;
  logic             task_ready;
  logic             task_done;
  logic             task_valid;
  logic [IDX_W-1:0] task_slot;
  logic [1:0]       task_color;
  logic [IDX_W-1:0] served_count;
  logic             all_done;
  state_t           dbg_state;

  always #10 clk_50m = ~clk_50m;

  sm_1118_spm_scheduler #(.NUM_SLOTS(7), .IDX_W(IDX_W)) dut (
    .clk_50m      (clk_50m),
    .rst_n        (rst_n),
    .rx_index     (rx_index),
    .rx_color     (rx_color),
    .restart      (restart),
    .task_ready   (task_ready),
    .task_done    (task_done),
    .task_valid   (task_valid),
    .task_slot    (task_slot),
    .task_color   (task_color),
    .served_count (served_count),
    .all_done     (all_done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_served = 0;

  int msg_full  [7] = '{1, 0, 2, 3, 0, 1, 2};  // R,N,B,G,N,R,B
  int msg_empty [7] = '{0, 0, 0, 0, 0, 0, 0};
  int e1_slot [5];
  int e1_col  [5];
  int e3_slot [3];
  int e3_col  [3];

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(task_valid), 32'd0);
    check({tag, "_slot"},  32'(task_slot), 32'd0);
    check({tag, "_color"}, 32'(task_color), 32'd0);
    check({tag, "_count"}, 32'(served_count), 32'd0);
    check({tag, "_done"},  32'(all_done), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(COLLECT));
  endtask

  task automatic put(input int idx, input int col, input int hold);
    rx_index = IDX_W'(idx);
    rx_color = 2'(col);
    repeat (hold) tick();
  endtask

  // Streams indices first..6 (4 cycles each), then index 7 with the
  // capture-to-offer latency checks.
  task automatic stream_msg(input int cols [7], input int first);
    bit any;
    any = 1'b0;
    for (int i = first; i <= 6; i++) put(i, cols[i-1], 4);
    for (int i = first; i <= 7; i++) if (cols[i-1] != 0) any = 1'b1;
    rx_index = IDX_W'(7);
    rx_color = 2'(cols[6]);
    tick();
    check("cap7_state_select", 32'(dbg_state), 32'(SELECT));
    check("cap7_valid_low", 32'(task_valid), 32'd0);
    check("cap7_done_low", 32'(all_done), 32'd0);
    tick();
    if (any) begin
      check("cap7_valid_n2", 32'(task_valid), 32'd1);
    end else begin
      check("cap7_alldone_n2", 32'(all_done), 32'd1);
      check("cap7_novalid_n2", 32'(task_valid), 32'd0);
    end
  endtask

  task automatic check_offer(input int slot, input int col);
    check("offer_valid", 32'(task_valid), 32'd1);
    check("offer_slot", 32'(task_slot), slot);
    check("offer_color", 32'(task_color), col);
    check("offer_state", 32'(dbg_state), 32'(OFFER));
  endtask

  task automatic accept();
    task_ready = 1'b1;
    tick();
    task_ready = 1'b0;
    check("accept_valid_drop", 32'(task_valid), 32'd0);
    check("accept_state", 32'(dbg_state), 32'(WAIT_DONE));
  endtask

  // Completion pulse, then next offer (or all_done) exactly 2 cycles later.
  task automatic complete(input bit last);
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    exp_served++;
    check("done_count", 32'(served_count), exp_served);
    check("done_gap_valid", 32'(task_valid), 32'd0);
    tick();
    if (last) begin
      check("final_alldone", 32'(all_done), 32'd1);
      check("final_novalid", 32'(task_valid), 32'd0);
    end else begin
      check("next_valid_m2", 32'(task_valid), 32'd1);
    end
  endtask

  task automatic serve(input int slot, input int col, input bit last);
    check_offer(slot, col);
    accept();
    repeat (2) tick();
    complete(last);
  endtask

  task automatic do_restart();
    restart  = 1'b1;
    rx_index = '0;
    rx_color = 2'd0;
    tick();
    restart  = 1'b0;
    exp_served = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
`ifdef SM_1118_COLOR_PRIORITY_EN
    e1_slot = '{1, 6, 3, 7, 4};  e1_col = '{1, 1, 2, 2, 3};
    e3_slot = '{6, 7, 5};        e3_col = '{1, 2, 3};
`else
    e1_slot = '{1, 3, 4, 6, 7};  e1_col = '{1, 2, 3, 1, 2};
    e3_slot = '{5, 6, 7};        e3_col = '{3, 1, 2};
`endif
    rst_n = 1'b0; rx_index = '0; rx_color = 2'd0;
    restart = 1'b0; task_ready = 1'b0; task_done = 1'b0;
    repeat (2) tick();
    check_cleared("reset");
    rst_n = 1'b1;
    tick();

    // Full message, every task acked and completed.
    stream_msg(msg_full, 1);
    for (int k = 0; k < 5; k++) serve(e1_slot[k], e1_col[k], k == 4);
    repeat (3) tick();
    check("full_alldone_hold", 32'(all_done), 32'd1);
    check("full_count", 32'(served_count), 32'd5);
    check("full_state", 32'(dbg_state), 32'(DONE));
    do_restart();
    check_cleared("restart_after_done");

    // Early terminator with out-of-range noise: only slots 5..7 streamed.
    put(9, 3, 2);
    put(8, 1, 2);
    put(5, 3, 4);
    put(6, 1, 4);
    check("early_still_collect", 32'(dbg_state), 32'(COLLECT));
    rx_index = IDX_W'(7); rx_color = 2'd2;
    tick();
    check("early_select", 32'(dbg_state), 32'(SELECT));
    tick();
    check_offer(e3_slot[0], e3_col[0]);
    // Stall the offer for 20 cycles; offer must stay stable.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("stall_valid", 32'(task_valid), 32'd1);
      check("stall_slot", 32'(task_slot), e3_slot[0]);
      check("stall_color", 32'(task_color), e3_col[0]);
    end
    // task_done while offering is ignored.
    task_done = 1'b1;
    tick();
    task_done = 1'b0;
    check("offer_done_ignored_cnt", 32'(served_count), 32'd0);
    check("offer_done_ignored_valid", 32'(task_valid), 32'd1);
    // task_done in the handshake cycle itself is ignored too.
    task_ready = 1'b1; task_done = 1'b1;
    tick();
    task_ready = 1'b0; task_done = 1'b0;
    check("hs_done_valid", 32'(task_valid), 32'd0);
    check("hs_done_state", 32'(dbg_state), 32'(WAIT_DONE));
    check("hs_done_cnt", 32'(served_count), 32'd0);
    repeat (2) tick();
    check("hs_done_still_wait", 32'(dbg_state), 32'(WAIT_DONE));
    complete(1'b0);
    serve(e3_slot[1], e3_col[1], 1'b0);
    serve(e3_slot[2], e3_col[2], 1'b1);
    check("early_count", 32'(served_count), 32'd3);
    do_restart();
    check_cleared("restart_after_early");

    // All slots empty: all_done 2 cycles after index-7 capture.
    stream_msg(msg_empty, 1);
    repeat (4) tick();
    check("empty_novalid", 32'(task_valid), 32'd0);
    check("empty_count", 32'(served_count), 32'd0);
    check("empty_alldone", 32'(all_done), 32'd1);
    do_restart();

    // rst_n during WAIT_DONE of task 3.
    stream_msg(msg_full, 1);
    serve(e1_slot[0], e1_col[0], 1'b0);
    serve(e1_slot[1], e1_col[1], 1'b0);
    check_offer(e1_slot[2], e1_col[2]);
    accept();
    tick();
    rst_n = 1'b0; rx_index = '0; rx_color = 2'd0;
    tick();
    rst_n = 1'b1;
    exp_served = 0;
    check_cleared("rst_in_wait");
    tick();
    check_cleared("rst_in_wait_hold");

    // restart during WAIT_DONE of task 3, after a fresh stream.
    stream_msg(msg_full, 1);
    serve(e1_slot[0], e1_col[0], 1'b0);
    serve(e1_slot[1], e1_col[1], 1'b0);
    check_offer(e1_slot[2], e1_col[2]);
    accept();
    do_restart();
    check_cleared("restart_in_wait");

    // Re-stream: schedule restarts from the first task; restart mid-OFFER.
    stream_msg(msg_full, 1);
    check_offer(e1_slot[0], e1_col[0]);
    check("restream_count", 32'(served_count), 32'd0);
    do_restart();
    check_cleared("restart_in_offer");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_sm_1118_spm_scheduler
